register_file_10_i: RTL and testbench



---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_reg64.sv | 29 ++
 rtl/register_file_10_i.sv | 52 +++++
 tb/tb_register_file_10_i.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and the address-window helper for the 16 x 64-bit register bank.
package rf_pkg;

  localparam logic [15:0] RF_BASE_ADDR = 16'h0110;
  localparam int          RF_NUM_REGS  = 16;
  localparam int          RF_DATA_W    = 64;
  localparam int          RF_ADDR_W    = 16;

  // Window match ignores the low nibble, which selects the register.
  function automatic logic rf_hit(input logic [RF_ADDR_W-1:0] addr,
                                  input logic [RF_ADDR_W-1:0] base = RF_BASE_ADDR);
    return (((addr ^ base) & 16'hFFF0) == 16'h0000);
  endfunction

endpackage

// File: rtl/rf_reg64.sv
// Data register with synchronous active-high clear and load enable; clear wins over load.
module rf_reg64
  import rf_pkg::*;
#(
  parameter int W = RF_DATA_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Storage element: clear, load or hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_r <= '0;
    end else if (ld) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/register_file_10_i.sv
// Bus-mapped bank of sixteen 64-bit registers: decoded single write port,
// combinational read port that returns zero outside the address window.
module register_file_10_i
  import rf_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = RF_BASE_ADDR,
  parameter int          NUM_REGS  = RF_NUM_REGS,
  parameter int          DATA_W    = RF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [15:0]       W_addr,
  input  logic [DATA_W-1:0] wData,
  input  logic [15:0]       R_addr,
  output logic [DATA_W-1:0] rData
);

  logic [NUM_REGS-1:0] wr_en_s;
  logic [DATA_W-1:0]   reg_q_s [NUM_REGS];

  // Write decoder: one-hot load enable, empty on a window miss.
  always_comb begin
    wr_en_s = '0;
    if (we && rf_hit(W_addr, BASE_ADDR)) begin
      wr_en_s[W_addr[3:0]] = 1'b1;
    end else begin
      wr_en_s = '0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    rf_reg64 #(.W(DATA_W)) u_reg (
      .clk (clk),
      .clr (reset_n),
      .ld  (wr_en_s[i]),
      .d   (wData),
      .q   (reg_q_s[i])
    );
  end

  // Read mux: no bypass of wData, out-of-window reads as zero.
  always_comb begin
    rData = '0;
    if (rf_hit(R_addr, BASE_ADDR)) begin
      rData = reg_q_s[R_addr[3:0]];
    end else begin
      rData = '0;
    end
  end

endmodule

// File: tb/tb_register_file_10_i.sv
// Self-checking bench: directed scenarios plus randomized traffic against an array model.
module tb_register_file_10_i;

  logic        clk;
  logic        reset_n;
  logic        we;
  logic [15:0] W_addr;
  logic [63:0] wData;
  logic [15:0] R_addr;
  logic [63:0] rData;

  int total;
  int bad;

  logic [63:0] model [16];

  register_file_10_i dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (we),
    .W_addr  (W_addr),
    .wData   (wData),
    .R_addr  (R_addr),
    .rData   (rData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_win(input logic [15:0] a);
    return (a >= 16'h0110) && (a <= 16'h011F);
  endfunction

  function automatic logic [63:0] exp_rd(input logic [15:0] a);
    if (in_win(a)) return model[int'(a) - 272];
    return 64'h0;
  endfunction

  // Reference model: reset clears everything, an in-window enabled write stores.
  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      for (int i = 0; i < 16; i++) model[i] = 64'h0;
    end else if (we === 1'b1 && in_win(W_addr)) begin
      model[int'(W_addr) - 272] = wData;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a);
    R_addr = a;
    #1;
    chk(tag, rData, exp_rd(a));
    #4;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    we = 1'b1;
    W_addr = a;
    wData = d;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] fill [12];
    logic [15:0] ra;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) model[i] = 64'hX;

    // Reset held with a concurrent miss write
    reset_n = 1'b1;
    we      = 1'b1;
    W_addr  = 16'h0120;
    wData   = 64'hFFFF_FFFF_0000_0000;
    R_addr  = 16'h0110;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      R_addr = 16'h0110 + 16'(i);
      #0.1;
      chk("reset_val", rData, 64'h0);
    end
    wr(16'h0120, 64'h1111_1111);
    idle();
    for (int i = 0; i < 16; i++) rd_chk("miss_wr", 16'h0110 + 16'(i));
    R_addr = 16'h0120;
    #1;
    chk("miss_rd", rData, 64'h0);

    // Sequential fill
    fill[0] = 64'hFFFF_FFFF_FF00_FF00;
    fill[1] = 64'hFFFF_FFFF_FF00_FF01;
    fill[2] = 64'hFFFF_FFFF_00FF_00FF;
    for (int i = 3; i < 12; i++) fill[i] = 64'hFFFF_FFFF_FF00_FF02 + 64'(i - 3);
    for (int i = 0; i < 12; i++) wr(16'h0110 + 16'(i), fill[i]);
    idle();
    for (int i = 0; i < 12; i++) begin
      R_addr = 16'h0110 + 16'(i);
      #1;
      chk("fill", rData, fill[i]);
      #4;
    end

    // Write-enable gating
    @(negedge clk);
    we = 1'b0;
    W_addr = 16'h0115;
    wData = 64'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    R_addr = 16'h0115;
    #1;
    chk("we_gate", rData, 64'hFFFF_FFFF_FF00_FF04);

    // Reset beats a simultaneous write
    @(negedge clk);
    reset_n = 1'b1;
    we = 1'b1;
    W_addr = 16'h011F;
    wData = 64'hA5A5;
    @(negedge clk);
    reset_n = 1'b0;
    we = 1'b0;
    R_addr = 16'h011F;
    #1;
    chk("rst_prio", rData, 64'h0);
    for (int i = 0; i < 16; i++) rd_chk("rst_all", 16'h0110 + 16'(i));
    wr(16'h011F, 64'hA5A5);
    idle();
    R_addr = 16'h011F;
    #1;
    chk("post_rst_wr", rData, 64'hA5A5);

    // Read-during-write: old value before the edge, new after
    wr(16'h0112, 64'h77);
    @(negedge clk);
    R_addr = 16'h0112;
    we = 1'b1;
    W_addr = 16'h0112;
    wData = 64'h1234;
    #1;
    chk("rdw_old", rData, 64'h77);
    @(posedge clk);
    #1;
    chk("rdw_new", rData, 64'h1234);
    idle();

    // Window boundaries
    wr(16'h0110, 64'h1);
    wr(16'h011F, 64'hF);
    wr(16'h010F, 64'hBAD0);
    wr(16'h0120, 64'hBAD1);
    idle();
    R_addr = 16'h0110; #1; chk("bnd_lo", rData, 64'h1);
    R_addr = 16'h011F; #1; chk("bnd_hi", rData, 64'hF);
    R_addr = 16'h010F; #1; chk("bnd_below", rData, 64'h0);
    R_addr = 16'h0120; #1; chk("bnd_above", rData, 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 39) == 0);
      we      = 1'($urandom_range(0, 1));
      W_addr  = 16'h0108 + 16'($urandom_range(0, 31));
      wData   = {$urandom, $urandom};
      ra      = 16'h0108 + 16'($urandom_range(0, 31));
      R_addr  = ra;
      #1;
      chk("rand", rData, exp_rd(ra));
    end
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) rd_chk("final", 16'h0110 + 16'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
